herald_engine_arbiter: RTL and testbench

//   Round-robin arbiter sharing one CORDIC/MAC compute engine (Herald command set) among

---
 rtl/herald_engine_arbiter_if.sv | 43 ++++
 rtl/herald_engine_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_herald_engine_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/herald_engine_arbiter_if.sv
// Bundle of requester, engine and response signals around the Herald engine arbiter.
// The master modport is the arbiter side; the slave modport is the environment side.
interface herald_engine_arbiter_if #(
   parameter int NREQ = 2
);
   localparam int IDW = (NREQ > 2) ? 2 : 1;

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [8*NREQ-1:0]    req_op;
   logic [24*NREQ-1:0]   req_a;
   logic [24*NREQ-1:0]   req_b;

   logic                 eng_start;
   logic [7:0]           eng_op;
   logic [23:0]          eng_a;
   logic [23:0]          eng_b;
   logic                 eng_busy;
   logic                 eng_done;
   logic [71:0]          eng_result;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [71:0]          rsp_data;
   logic                 rsp_err;

   logic                 lock_valid;
   logic [IDW-1:0]       lock_owner;
   logic                 arb_busy;

   modport master (
      input  req_valid, req_op, req_a, req_b, eng_busy, eng_done, eng_result, rsp_ready,
      output req_ready, eng_start, eng_op, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, rsp_err,
             lock_valid, lock_owner, arb_busy
   );

   modport slave (
      output req_valid, req_op, req_a, req_b, eng_busy, eng_done, eng_result, rsp_ready,
      input  req_ready, eng_start, eng_op, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, rsp_err,
             lock_valid, lock_owner, arb_busy
   );
endinterface

// File: rtl/herald_engine_arbiter.sv
// Round-robin arbiter sharing one CORDIC/MAC engine among NREQ requesters, with a MAC accumulator lock.
// Grant is combinational in IDLE; one command in flight; response held until rsp_ready, no grant meanwhile.
module herald_engine_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 256
) (
   input logic                      clk,
   input logic                      rst_n,
   herald_engine_arbiter_if.master  bus
);
   localparam int IDW = (NREQ > 2) ? 2 : 1;
   localparam int TW  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic [7:0]  op;
      logic [23:0] a;
      logic [23:0] b;
   } cmd_t;

   state_t          state_q, state_d;
   cmd_t            cmd_q, cmd_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  last_grant_q, last_grant_d;
   logic [IDW-1:0]  lock_owner_q, lock_owner_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            eng_start_q, eng_start_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic            lock_valid_q, lock_valid_d;
   logic [71:0]     rsp_data_q, rsp_data_d;

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] ready;
   logic            grant_vld;
   logic [IDW-1:0]  grant_idx;

   function automatic logic is_acc(input logic [7:0] op);
      return (op == 8'h21) || (op == 8'h22) || (op == 8'h23);
   endfunction

   function automatic logic is_valid_op(input logic [7:0] op);
      return (op[7:2] == 6'b000100) || (op[7:2] == 6'b001000);
   endfunction

   // Foreign accumulator ops are masked while another requester holds the lock.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = bus.req_valid[i] &
                       !(lock_valid_q && (lock_owner_q != IDW'(i)) && is_acc(bus.req_op[8*i +: 8]));
      end
   end

   // Scan farthest-first so the index right after last_grant wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(last_grant_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (eligible[IDW'(idx)]) begin
            grant_vld = 1'b1;
            grant_idx = IDW'(idx);
         end
      end
   end

   always_comb begin
      ready = '0;
      if ((state_q == S_IDLE) && grant_vld) ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      eng_start_d  = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_err_d    = rsp_err_q;
      rsp_data_d   = rsp_data_q;
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               id_d = grant_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (grant_idx == IDW'(i)) begin
                     cmd_d.op = bus.req_op[8*i +: 8];
                     cmd_d.a  = bus.req_a[24*i +: 24];
                     cmd_d.b  = bus.req_b[24*i +: 24];
                  end
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!is_valid_op(cmd_q.op)) begin
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (!bus.eng_busy) begin
               eng_start_d = 1'b1;
               timer_d     = '0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.eng_done) begin
               rsp_data_d  = bus.eng_result;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
               if ((cmd_q.op == 8'h21) || (cmd_q.op == 8'h23)) begin
                  lock_valid_d = 1'b1;
                  lock_owner_d = id_q;
               end else if ((cmd_q.op == 8'h22) && (!lock_valid_q || (lock_owner_q == id_q))) begin
                  lock_valid_d = 1'b0;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d  = 1'b0;
               last_grant_d = id_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cmd_q        <= '0;
         id_q         <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         timer_q      <= '0;
         eng_start_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
         lock_valid_q <= 1'b0;
         lock_owner_q <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         eng_start_q  <= eng_start_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   assign bus.req_ready  = ready;
   assign bus.eng_start  = eng_start_q;
   assign bus.eng_op     = cmd_q.op;
   assign bus.eng_a      = cmd_q.a;
   assign bus.eng_b      = cmd_q.b;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.lock_valid = lock_valid_q;
   assign bus.lock_owner = lock_owner_q;
   assign bus.arb_busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_herald_engine_arbiter.sv
// Directed and randomized transactions against a transaction-level model of arbitration, lock and timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_herald_engine_arbiter;
   localparam int NREQ = 2;
   localparam int TMO  = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   int   m_last;
   bit   m_lock_v;
   int   m_lock_o;

   logic [7:0]  t_op [NREQ];
   logic [23:0] t_a  [NREQ];
   logic [23:0] t_b  [NREQ];
   logic [7:0]  ops  [13] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                             8'h55, 8'h00, 8'hFF, 8'h14, 8'h24};

   herald_engine_arbiter_if #(.NREQ(NREQ)) bus ();

   herald_engine_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] rand72();
      return {8'($urandom()), $urandom(), $urandom()};
   endfunction

   function automatic bit m_acc(input logic [7:0] op);
      return (op == 8'h21) || (op == 8'h22) || (op == 8'h23);
   endfunction

   function automatic bit m_valid(input logic [7:0] op);
      return ((op >= 8'h10) && (op <= 8'h13)) || ((op >= 8'h20) && (op <= 8'h23));
   endfunction

   function automatic int m_grant(input logic [NREQ-1:0] vm);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (m_last + k) % NREQ;
         if (vm[idx] && !(m_lock_v && (m_lock_o != idx) && m_acc(t_op[idx]))) return idx;
      end
      return -1;
   endfunction

   task automatic drive_reqs(input logic [NREQ-1:0] vm);
      bus.req_valid = vm;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_op[8*i +: 8]  = t_op[i];
         bus.req_a[24*i +: 24] = t_a[i];
         bus.req_b[24*i +: 24] = t_b[i];
      end
   endtask

   // lat <= 0 means the engine never completes.
   task automatic txn(input string tag, input logic [NREQ-1:0] vm, input int lat,
                      input logic [71:0] res, input int busy_n, input int rdy_dly);
      int          g_exp, g, start_c, n_start, resp_c, exp_start, exp_resp;
      logic        stray, unstable, vop, ok, exp_err;
      logic [71:0] exp_data;
      g_exp = m_grant(vm);
      drive_reqs(vm);
      bus.eng_busy = (busy_n > 0);
      if (g_exp < 0) begin
         stray = 1'b0;
         repeat (4) begin
            #1;
            if (bus.req_ready != '0) stray = 1'b1;
            @(negedge clk);
         end
         chk({tag, "/stall_ready"}, stray, 0);
         chk({tag, "/stall_idle"}, bus.arb_busy, 0);
         bus.req_valid = '0;
         bus.eng_busy  = 1'b0;
         return;
      end
      #1;
      g = -1;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      chk({tag, "/grant"}, g, g_exp);
      chk({tag, "/ready_vec"}, bus.req_ready, 1 << g_exp);

      vop      = m_valid(t_op[g_exp]);
      ok       = vop && (lat >= 1) && (lat <= TMO);
      exp_err  = !ok;
      exp_data = ok ? res : 72'd0;
      exp_start = (busy_n > 1) ? busy_n + 1 : 2;
      exp_resp  = !vop ? 2 : exp_start + (ok ? lat : TMO);

      n_start = 0; start_c = 0; resp_c = 0; stray = 1'b0;
      for (int cc = 1; cc <= 200; cc++) begin
         @(negedge clk);
         if (bus.req_ready != '0) stray = 1'b1;
         if (bus.rsp_valid) begin
            resp_c = cc;
            break;
         end
         if (bus.eng_start) begin
            n_start++;
            if (start_c == 0) start_c = cc;
         end
         bus.eng_busy   = (cc < busy_n);
         bus.eng_done   = (start_c > 0) && (lat > 0) && (cc == start_c + lat - 1);
         bus.eng_result = bus.eng_done ? res : rand72();
      end
      bus.eng_done = 1'b0;
      bus.eng_busy = 1'b0;

      chk({tag, "/rsp_cycle"}, resp_c, exp_resp);
      chk({tag, "/start_count"}, n_start, vop ? 1 : 0);
      if (vop) chk({tag, "/start_cycle"}, start_c, exp_start);
      chk({tag, "/no_ready_inflight"}, stray, 0);
      chk({tag, "/rsp_id"}, bus.rsp_id, g_exp);
      chk({tag, "/rsp_err"}, bus.rsp_err, exp_err);
      chk({tag, "/rsp_data"}, bus.rsp_data, exp_data);
      chk({tag, "/eng_cmd"}, {bus.eng_op, bus.eng_a, bus.eng_b}, {t_op[g_exp], t_a[g_exp], t_b[g_exp]});

      unstable = 1'b0; stray = 1'b0;
      for (int d = 0; d < rdy_dly; d++) begin
         @(negedge clk);
         if (!bus.rsp_valid || (int'(bus.rsp_id) != g_exp) || (bus.rsp_data !== exp_data) ||
             (bus.rsp_err !== exp_err)) unstable = 1'b1;
         if (bus.req_ready != '0) stray = 1'b1;
      end
      bus.rsp_ready = 1'b1;
      #1;
      if (bus.req_ready != '0) stray = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      if (rdy_dly > 0) chk({tag, "/rsp_stable"}, unstable, 0);
      chk({tag, "/no_ready_resp"}, stray, 0);
      chk({tag, "/rsp_dropped"}, {bus.rsp_valid, bus.arb_busy}, 0);

      if (ok && ((t_op[g_exp] == 8'h21) || (t_op[g_exp] == 8'h23))) begin
         m_lock_v = 1'b1;
         m_lock_o = g_exp;
      end else if (ok && (t_op[g_exp] == 8'h22) && (!m_lock_v || (m_lock_o == g_exp))) begin
         m_lock_v = 1'b0;
      end
      m_last = g_exp;
      chk({tag, "/lock_valid"}, bus.lock_valid, m_lock_v);
      if (m_lock_v) chk({tag, "/lock_owner"}, bus.lock_owner, m_lock_o);
      bus.req_valid = '0;
   endtask

   initial begin
      logic [NREQ-1:0] vm_r;
      int              lat, r;
      logic            seen;
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.eng_busy   = 1'b0;
      bus.eng_done   = 1'b0;
      bus.eng_result = '0;
      bus.rsp_ready  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
      end
      m_last = NREQ - 1; m_lock_v = 1'b0; m_lock_o = 0;

      repeat (3) @(negedge clk);
      chk("reset_ctl", {bus.req_ready, bus.eng_start, bus.rsp_valid, bus.rsp_err, bus.lock_valid,
                        bus.arb_busy, bus.rsp_id, bus.lock_owner}, 0);
      chk("reset_dat", {bus.eng_op, bus.eng_a, bus.eng_b, bus.rsp_data}, 0);
      rst_n = 1'b1;

      // Fair alternation from reset: 0,1,0,1
      t_op[0] = 8'h20; t_a[0] = 24'h000111; t_b[0] = 24'h000222;
      t_op[1] = 8'h20; t_a[1] = 24'h000333; t_b[1] = 24'h000444;
      for (int n = 0; n < 4; n++) txn("rr", 2'b11, 2 + n, rand72(), 0, 0);

      t_op[0] = 8'h10; t_a[0] = 24'h000C90; t_b[0] = 24'h000100;
      txn("cordic", 2'b01, 20, 72'h123, 0, 0);

      // Lock ownership
      t_op[1] = 8'h21; txn("lock_take", 2'b10, 5, rand72(), 0, 0);
      t_op[0] = 8'h21; t_op[1] = 8'h20; txn("lock_other", 2'b11, 3, rand72(), 0, 1);
      txn("lock_stall", 2'b01, 3, rand72(), 0, 0);
      t_op[1] = 8'h22; txn("lock_release", 2'b10, 4, rand72(), 0, 0);
      t_op[0] = 8'h21; t_op[1] = 8'h20; txn("lock_regrant", 2'b11, 3, rand72(), 0, 0);

      // Timeout boundaries; owner's failed release keeps the lock
      t_op[0] = 8'h22; txn("tmo_none", 2'b01, 0, rand72(), 0, 0);
      t_op[1] = 8'h10; txn("tmo_last", 2'b10, TMO, rand72(), 0, 0);
      t_op[0] = 8'h11; txn("tmo_over", 2'b01, TMO + 1, rand72(), 0, 0);
      t_op[0] = 8'h22; txn("unlock", 2'b01, 2, rand72(), 0, 0);

      // Bad opcode and busy engine
      t_op[1] = 8'h55; txn("bad_op", 2'b10, 3, rand72(), 3, 0);
      t_op[0] = 8'h12; txn("busy_defer", 2'b01, 1, rand72(), 6, 0);

      t_op[1] = 8'h13; txn("rsp_hold", 2'b10, 3, rand72(), 0, 10);

      // Reset in the middle of WAIT
      t_op[0] = 8'h23; txn("rst_lock", 2'b01, 4, rand72(), 0, 0);
      t_op[1] = 8'h10;
      drive_reqs(2'b10);
      #1;
      chk("rst_grant", bus.req_ready, 2'b10);
      repeat (4) @(negedge clk);
      chk("rst_in_wait", {bus.arb_busy, bus.lock_valid}, 2'b11);
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", {bus.req_ready, bus.eng_start, bus.rsp_valid, bus.rsp_err, bus.lock_valid,
                          bus.arb_busy, bus.rsp_id, bus.lock_owner}, 0);
      chk("rst_mid_dat", {bus.eng_op, bus.eng_a, bus.eng_b, bus.rsp_data}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_last = NREQ - 1; m_lock_v = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.eng_done   = (c == 1);
         bus.eng_result = rand72();
         @(negedge clk);
         if (bus.rsp_valid || bus.arb_busy) seen = 1'b1;
      end
      bus.eng_done = 1'b0;
      chk("rst_no_rsp", seen, 0);
      t_op[0] = 8'h10; t_op[1] = 8'h10;
      txn("rst_prio", 2'b11, 3, rand72(), 0, 0);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            t_op[i] = ops[$urandom_range(0, 12)];
            t_a[i]  = 24'($urandom());
            t_b[i]  = 24'($urandom());
         end
         r   = int'($urandom_range(0, 19));
         lat = (r == 0) ? 0 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : int'($urandom_range(1, 10));
         vm_r = 2'($urandom_range(1, 3));
         txn("rnd", vm_r, lat, rand72(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
